// File: rtl/mem_access_pkg.sv
// Shared RV32I load/store encodings used by the memory-access stage.
package mem_access_pkg;

  // Memory operation encoding carried from execute.
  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;
  localparam logic [1:0] MEM_RSVD  = 2'd3;

  // Load/store width encodings (funct3).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when the access is misaligned or its width code is illegal.
  // Unsigned widths exist only for loads.
  function automatic logic access_bad(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] a);
    case (f3)
      F3_B:    return 1'b0;
      F3_H:    return a[0];
      F3_W:    return (a != 2'b00);
      F3_BU:   return is_store;
      F3_HU:   return is_store | a[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// Byte-lane logic: byte enables, store replication, load extract and extend.
module lsu_align
  import mem_access_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        bad,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pure lane steering; the same unit serves the request and the response side.
  always_comb begin
    bad        = access_bad(is_store, funct3, addr_lo);
    byte_shift = rdata >> {addr_lo, 3'b000};
    half_shift = rdata >> {addr_lo[1], 4'b0000};
    lane_b     = byte_shift[7:0];
    lane_h     = half_shift[15:0];
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
    case (funct3)
      F3_B:    rdata_ext = {{24{lane_b[7]}}, lane_b};
      F3_BU:   rdata_ext = {24'h000000, lane_b};
      F3_H:    rdata_ext = {{16{lane_h[15]}}, lane_h};
      F3_HU:   rdata_ext = {16'h0000, lane_h};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: passes ALU results through, runs one bus access per
// load/store, and reports misalignment and bus timeouts via writeback pulses.
// Handshake: a request transfers on a rising edge where i_valid && o_ready;
// o_ready is high only while idle. Writeback has no backpressure.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_rd_we,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data,
  input  logic [1:0]  i_mem_op,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  output logic        o_bus_req,
  input  logic        i_bus_gnt,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_wb_valid,
  output logic        o_wb_rd_we,
  output logic [4:0]  o_wb_rd_addr,
  output logic [31:0] o_wb_rd_data,
  output logic        o_exc_misalign,
  output logic        o_exc_timeout,
  output logic [31:0] o_exc_addr,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS_REQ  = 2'd1,
    BUS_WAIT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] lat_addr;
  logic [2:0]  lat_funct3;
  logic [4:0]  lat_rd_addr;
  logic        lat_store;

  logic        idle;
  logic        sel_store;
  logic [2:0]  sel_funct3;
  logic [1:0]  sel_addr_lo;
  logic        bad;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;
  logic        is_mem;
  logic        timeout_hit;

  // Align unit sees the live request while idle and the latched one during an access.
  always_comb begin
    idle        = (state == IDLE);
    sel_store   = idle ? (i_mem_op == MEM_STORE) : lat_store;
    sel_funct3  = idle ? i_funct3 : lat_funct3;
    sel_addr_lo = idle ? i_mem_addr[1:0] : lat_addr[1:0];
    is_mem      = (i_mem_op == MEM_LOAD) || (i_mem_op == MEM_STORE);
    timeout_hit = (TIMEOUT_CYC != 0) && ((cnt + 32'd1) == TIMEOUT_CYC);
  end

  lsu_align u_align (
    .is_store  (sel_store),
    .funct3    (sel_funct3),
    .addr_lo   (sel_addr_lo),
    .wdata     (i_mem_wdata),
    .rdata     (i_bus_rdata),
    .bad       (bad),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  assign o_dbg_state = state;

  // Access FSM with registered bus, writeback and exception outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_addr       <= '0;
      lat_funct3     <= '0;
      lat_rd_addr    <= '0;
      lat_store      <= 1'b0;
      o_ready        <= 1'b0;
      o_bus_req      <= 1'b0;
      o_bus_we       <= 1'b0;
      o_bus_addr     <= '0;
      o_bus_be       <= '0;
      o_bus_wdata    <= '0;
      o_wb_valid     <= 1'b0;
      o_wb_rd_we     <= 1'b0;
      o_wb_rd_addr   <= '0;
      o_wb_rd_data   <= '0;
      o_exc_misalign <= 1'b0;
      o_exc_timeout  <= 1'b0;
      o_exc_addr     <= '0;
    end else begin
      o_wb_valid     <= 1'b0;
      o_exc_misalign <= 1'b0;
      o_exc_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          o_ready <= 1'b1;
          if (i_valid && o_ready) begin
            lat_addr    <= i_mem_addr;
            lat_funct3  <= i_funct3;
            lat_rd_addr <= i_rd_addr;
            lat_store   <= (i_mem_op == MEM_STORE);
            if (!is_mem) begin
              o_wb_valid   <= 1'b1;
              o_wb_rd_we   <= i_rd_we && (i_rd_addr != 5'd0);
              o_wb_rd_addr <= i_rd_addr;
              o_wb_rd_data <= i_rd_data;
            end else if (bad) begin
              o_wb_valid     <= 1'b1;
              o_wb_rd_we     <= 1'b0;
              o_wb_rd_addr   <= i_rd_addr;
              o_wb_rd_data   <= '0;
              o_exc_misalign <= 1'b1;
              o_exc_addr     <= i_mem_addr;
            end else begin
              state       <= BUS_REQ;
              o_ready     <= 1'b0;
              cnt         <= '0;
              o_bus_req   <= 1'b1;
              o_bus_we    <= (i_mem_op == MEM_STORE);
              o_bus_addr  <= {i_mem_addr[31:2], 2'b00};
              o_bus_be    <= be;
              o_bus_wdata <= wdata_rep;
            end
          end
        end
        BUS_REQ: begin
          if (i_bus_gnt) begin
            o_bus_req <= 1'b0;
            cnt       <= '0;
            if (lat_store || i_bus_rvalid) begin
              state        <= IDLE;
              o_ready      <= 1'b1;
              o_wb_valid   <= 1'b1;
              o_wb_rd_we   <= !lat_store && (lat_rd_addr != 5'd0);
              o_wb_rd_addr <= lat_rd_addr;
              o_wb_rd_data <= lat_store ? 32'd0 : rdata_ext;
            end else begin
              state <= BUS_WAIT;
            end
          end else if (timeout_hit) begin
            state         <= IDLE;
            o_ready       <= 1'b1;
            o_bus_req     <= 1'b0;
            o_wb_valid    <= 1'b1;
            o_wb_rd_we    <= 1'b0;
            o_wb_rd_addr  <= lat_rd_addr;
            o_wb_rd_data  <= '0;
            o_exc_timeout <= 1'b1;
            o_exc_addr    <= lat_addr;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        BUS_WAIT: begin
          if (i_bus_rvalid) begin
            state        <= IDLE;
            o_ready      <= 1'b1;
            o_wb_valid   <= 1'b1;
            o_wb_rd_we   <= (lat_rd_addr != 5'd0);
            o_wb_rd_addr <= lat_rd_addr;
            o_wb_rd_data <= rdata_ext;
          end else if (timeout_hit) begin
            state         <= IDLE;
            o_ready       <= 1'b1;
            o_wb_valid    <= 1'b1;
            o_wb_rd_we    <= 1'b0;
            o_wb_rd_addr  <= lat_rd_addr;
            o_wb_rd_data  <= '0;
            o_exc_timeout <= 1'b1;
            o_exc_addr    <= lat_addr;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: scoreboard of expected writebacks plus
// direct bus-side checks at each step.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_rd_we = 1'b0;
  logic [4:0]  i_rd_addr = '0;
  logic [31:0] i_rd_data = '0;
  logic [1:0]  i_mem_op = '0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_mem_addr = '0;
  logic [31:0] i_mem_wdata = '0;
  logic        o_bus_req;
  logic        i_bus_gnt = 1'b0;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_rvalid = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic        o_wb_valid;
  logic        o_wb_rd_we;
  logic [4:0]  o_wb_rd_addr;
  logic [31:0] o_wb_rd_data;
  logic        o_exc_misalign;
  logic        o_exc_timeout;
  logic [31:0] o_exc_addr;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;

  // {exc_timeout, exc_misalign, rd_we, rd_addr[4:0], rd_data[31:0], exc_addr[31:0]}
  logic [71:0] exp_q[$];

  mem_access #(.TIMEOUT_CYC(4)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_rd_we        (i_rd_we),
    .i_rd_addr      (i_rd_addr),
    .i_rd_data      (i_rd_data),
    .i_mem_op       (i_mem_op),
    .i_funct3       (i_funct3),
    .i_mem_addr     (i_mem_addr),
    .i_mem_wdata    (i_mem_wdata),
    .o_bus_req      (o_bus_req),
    .i_bus_gnt      (i_bus_gnt),
    .o_bus_we       (o_bus_we),
    .o_bus_addr     (o_bus_addr),
    .o_bus_be       (o_bus_be),
    .o_bus_wdata    (o_bus_wdata),
    .i_bus_rvalid   (i_bus_rvalid),
    .i_bus_rdata    (i_bus_rdata),
    .o_wb_valid     (o_wb_valid),
    .o_wb_rd_we     (o_wb_rd_we),
    .o_wb_rd_addr   (o_wb_rd_addr),
    .o_wb_rd_data   (o_wb_rd_data),
    .o_exc_misalign (o_exc_misalign),
    .o_exc_timeout  (o_exc_timeout),
    .o_exc_addr     (o_exc_addr),
    .o_dbg_state    (o_dbg_state)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Scoreboard: every writeback pulse must match the oldest expected entry.
  always @(negedge i_clk) begin
    logic [71:0] e;
    if (o_bus_req === 1'b1) req_cycles++;
    if (o_wb_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL wb_unexpected got rd_we=%b rd=%0d data=%h exp no writeback",
               o_wb_rd_we, o_wb_rd_addr, o_wb_rd_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({o_exc_timeout, o_exc_misalign, o_wb_rd_we} === e[71:69]) else begin
          errors++;
          $error("FAIL wb_flags got %b exp %b", {o_exc_timeout, o_exc_misalign, o_wb_rd_we}, e[71:69]);
        end
        if (e[69]) begin
          checks++;
          assert ({o_wb_rd_addr, o_wb_rd_data} === e[68:32]) else begin
            errors++;
            $error("FAIL wb_data got rd=%0d %h exp rd=%0d %h", o_wb_rd_addr, o_wb_rd_data,
                   e[68:64], e[63:32]);
          end
        end
        if (e[71] | e[70]) begin
          checks++;
          assert (o_exc_addr === e[31:0]) else begin
            errors++;
            $error("FAIL exc_addr got %h exp %h", o_exc_addr, e[31:0]);
          end
        end
      end
    end else begin
      checks++;
      assert ((o_exc_timeout | o_exc_misalign) === 1'b0) else begin
        errors++;
        $error("FAIL exc_without_wb got %b%b exp 00", o_exc_timeout, o_exc_misalign);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic t, input logic m, input logic we, input logic [4:0] rd,
                          input logic [31:0] data, input logic [31:0] eaddr);
    exp_q.push_back({t, m, we, rd, data, eaddr});
  endtask

  // Driver: waits (bounded) for o_ready, presents one request for one edge.
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic we, input logic [4:0] rd,
                      input logic [31:0] rdata);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", {31'd0, o_ready}, 32'd1);
    i_valid     = 1'b1;
    i_mem_op    = op;
    i_funct3    = f3;
    i_mem_addr  = addr;
    i_mem_wdata = wdata;
    i_rd_we     = we;
    i_rd_addr   = rd;
    i_rd_data   = rdata;
    step();
    i_valid = 1'b0;
  endtask

  initial begin
    int r0;
    logic [31:0] rnd;
    logic seen;

    // Reset
    repeat (3) step();
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_req", {31'd0, o_bus_req}, 32'd0);
    chk("rst_wb", {31'd0, o_wb_valid}, 32'd0);
    i_rst_n = 1'b1;
    step();
    chk("ready_after_rst", {31'd0, o_ready}, 32'd1);

    // Pass-through, back to back
    rnd = $urandom_range(32'h7fffffff, 1);
    push_exp(0, 0, 1, 5'd5, rnd, 0);
    send(MEM_NONE, F3_W, 32'h0, 32'h0, 1'b1, 5'd5, rnd);
    chk("pass_ready", {31'd0, o_ready}, 32'd1);
    push_exp(0, 0, 0, 5'd0, 32'h0, 0);
    send(MEM_RSVD, F3_W, 32'h0, 32'h0, 1'b1, 5'd0, 32'hCAFE0000);
    push_exp(0, 0, 0, 5'd9, 32'h0, 0);
    send(MEM_NONE, F3_W, 32'h0, 32'h0, 1'b0, 5'd9, 32'h11111111);
    chk("pass_no_req", {31'd0, o_bus_req}, 32'd0);

    // SB at 0x103, grant after one idle cycle
    push_exp(0, 0, 0, 5'd3, 32'h0, 0);
    send(MEM_STORE, F3_B, 32'h103, 32'h000000A5, 1'b0, 5'd3, 32'h0);
    chk("sb_req", {31'd0, o_bus_req}, 32'd1);
    chk("sb_we", {31'd0, o_bus_we}, 32'd1);
    chk("sb_addr", o_bus_addr, 32'h100);
    chk("sb_be", {28'd0, o_bus_be}, 32'h8);
    chk("sb_wdata", o_bus_wdata, 32'hA5A5A5A5);
    step();
    chk("sb_hold_req", {31'd0, o_bus_req}, 32'd1);
    chk("sb_hold_addr", o_bus_addr, 32'h100);
    chk("sb_hold_wdata", o_bus_wdata, 32'hA5A5A5A5);
    i_bus_gnt = 1'b1;
    step();
    i_bus_gnt = 1'b0;
    chk("sb_req_drop", {31'd0, o_bus_req}, 32'd0);
    chk("sb_wb", {31'd0, o_wb_valid}, 32'd1);

    // SH and SW
    push_exp(0, 0, 0, 5'd4, 32'h0, 0);
    send(MEM_STORE, F3_H, 32'h12, 32'h1234BEEF, 1'b0, 5'd4, 32'h0);
    chk("sh_be", {28'd0, o_bus_be}, 32'hC);
    chk("sh_wdata", o_bus_wdata, 32'hBEEFBEEF);
    chk("sh_addr", o_bus_addr, 32'h10);
    i_bus_gnt = 1'b1;
    step();
    i_bus_gnt = 1'b0;
    push_exp(0, 0, 0, 5'd4, 32'h0, 0);
    send(MEM_STORE, F3_W, 32'h20, 32'hDEADBEEF, 1'b0, 5'd4, 32'h0);
    chk("sw_be", {28'd0, o_bus_be}, 32'hF);
    chk("sw_wdata", o_bus_wdata, 32'hDEADBEEF);
    i_bus_gnt = 1'b1;
    step();
    i_bus_gnt = 1'b0;

    // LB / LBU / LHU with grant and data in the same cycle
    push_exp(0, 0, 1, 5'd7, 32'hFFFFFF80, 0);
    send(MEM_LOAD, F3_B, 32'h102, 32'h0, 1'b1, 5'd7, 32'h0);
    chk("lb_be", {28'd0, o_bus_be}, 32'h4);
    chk("lb_we", {31'd0, o_bus_we}, 32'd0);
    i_bus_gnt = 1'b1; i_bus_rvalid = 1'b1; i_bus_rdata = 32'h0080FF00;
    step();
    i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
    chk("lb_req_drop", {31'd0, o_bus_req}, 32'd0);
    push_exp(0, 0, 1, 5'd8, 32'h00000080, 0);
    send(MEM_LOAD, F3_BU, 32'h102, 32'h0, 1'b1, 5'd8, 32'h0);
    i_bus_gnt = 1'b1; i_bus_rvalid = 1'b1; i_bus_rdata = 32'h0080FF00;
    step();
    i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
    push_exp(0, 0, 1, 5'd6, 32'h00008001, 0);
    send(MEM_LOAD, F3_HU, 32'h32, 32'h0, 1'b1, 5'd6, 32'h0);
    i_bus_gnt = 1'b1; i_bus_rvalid = 1'b1; i_bus_rdata = 32'h80011234;
    step();
    i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;

    // Misaligned / illegal width: no bus activity
    r0 = req_cycles;
    push_exp(0, 1, 0, 5'd2, 32'h0, 32'h206);
    send(MEM_LOAD, F3_W, 32'h206, 32'h0, 1'b1, 5'd2, 32'h0);
    chk("lw_mis_pulse", {31'd0, o_exc_misalign}, 32'd1);
    push_exp(0, 1, 0, 5'd2, 32'h0, 32'h300);
    send(MEM_LOAD, 3'b011, 32'h300, 32'h0, 1'b1, 5'd2, 32'h0);
    push_exp(0, 1, 0, 5'd2, 32'h0, 32'h44);
    send(MEM_STORE, F3_BU, 32'h44, 32'h0, 1'b0, 5'd2, 32'h0);
    step();
    chk("mis_pulse_end", {31'd0, o_exc_misalign}, 32'd0);
    chk("mis_no_req", req_cycles - r0, 32'd0);

    // Stray rvalid while idle is ignored
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h12345678;
    step();
    step();
    i_bus_rvalid = 1'b0;
    chk("stray_rvalid", {31'd0, o_wb_valid}, 32'd0);

    // LH with grant after three cycles, data two cycles after grant
    push_exp(0, 0, 1, 5'd10, 32'hFFFF8001, 0);
    send(MEM_LOAD, F3_H, 32'h32, 32'h0, 1'b1, 5'd10, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("lh_ready_req", {31'd0, o_ready}, 32'd0);
      chk("lh_req_held", {31'd0, o_bus_req}, 32'd1);
      step();
    end
    i_bus_gnt = 1'b1;
    step();
    i_bus_gnt = 1'b0;
    chk("lh_ready_gnt", {31'd0, o_ready}, 32'd0);
    chk("lh_req_drop", {31'd0, o_bus_req}, 32'd0);
    step();
    chk("lh_ready_wait", {31'd0, o_ready}, 32'd0);
    chk("lh_no_early_wb", {31'd0, o_wb_valid}, 32'd0);
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h80011234;
    step();
    i_bus_rvalid = 1'b0;
    chk("lh_wb_timing", {31'd0, o_wb_valid}, 32'd1);
    step();
    chk("lh_wb_single", {31'd0, o_wb_valid}, 32'd0);

    // Timeout: grant never arrives
    r0 = req_cycles;
    push_exp(1, 0, 0, 5'd11, 32'h0, 32'h40);
    send(MEM_LOAD, F3_W, 32'h40, 32'h0, 1'b1, 5'd11, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (o_wb_valid === 1'b1) seen = 1'b1;
    end
    chk("to_seen", {31'd0, seen}, 32'd1);
    chk("to_pulse", {31'd0, o_exc_timeout}, 32'd1);
    chk("to_req_cycles", req_cycles - r0, 32'd4);
    chk("to_req_low", {31'd0, o_bus_req}, 32'd0);
    chk("to_ready", {31'd0, o_ready}, 32'd1);

    // Reset while requesting
    send(MEM_LOAD, F3_W, 32'h60, 32'h0, 1'b1, 5'd12, 32'h0);
    chk("rq_req", {31'd0, o_bus_req}, 32'd1);
    i_rst_n = 1'b0;
    step();
    chk("rq_rst_req", {31'd0, o_bus_req}, 32'd0);
    i_rst_n = 1'b1;
    step();

    // Reset while waiting for data, then late data must not write back
    send(MEM_LOAD, F3_W, 32'h50, 32'h0, 1'b1, 5'd13, 32'h0);
    i_bus_gnt = 1'b1;
    step();
    i_bus_gnt = 1'b0;
    i_rst_n = 1'b0;
    step();
    chk("bw_rst_req", {31'd0, o_bus_req}, 32'd0);
    i_rst_n = 1'b1;
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h55555555;
    step();
    i_bus_rvalid = 1'b0;
    chk("bw_no_wb", {31'd0, o_wb_valid}, 32'd0);
    chk("bw_ready", {31'd0, o_ready}, 32'd1);
    repeat (3) step();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
